// File: rtl/mono_pkg.sv
// Shared constants, FSM state type and timestamp encoder for the MONOPIX transmitter emulator.
package mono_pkg;
  localparam int COL_BITS = 6;
  localparam int ROW_BITS = 8;
  localparam int TS_BITS  = 6;
  localparam int WB       = COL_BITS + ROW_BITS + 2*TS_BITS;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} tx_state_t;
  typedef logic [TS_BITS-1:0] ts_t;

  function automatic ts_t bin2gray(input ts_t b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/mono_data_tx_emu_if.sv
// Hit injection and TOKEN/READ/FREEZE/DATA bus between receiver (master) and chip emulator (slave).
interface mono_data_tx_emu_if;
  import mono_pkg::*;
  logic                HIT_WR;
  logic [COL_BITS-1:0] HIT_COL;
  logic [ROW_BITS-1:0] HIT_ROW;
  logic [TS_BITS-1:0]  HIT_LE;
  logic [TS_BITS-1:0]  HIT_TE;
  logic                FREEZE;
  logic                READ;
  logic                TOKEN;
  logic                DATA;
  logic                BUSY;
  logic [7:0]          LOST_CNT;
  logic [7:0]          READ_ERR;

  modport master (output HIT_WR, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, FREEZE, READ,
                  input  TOKEN, DATA, BUSY, LOST_CNT, READ_ERR);
  modport slave  (input  HIT_WR, HIT_COL, HIT_ROW, HIT_LE, HIT_TE, FREEZE, READ,
                  output TOKEN, DATA, BUSY, LOST_CNT, READ_ERR);
endinterface

// File: rtl/mono_tx_hit_fifo.sv
// Synchronous hit FIFO; a push while full is accepted only if a pop happens in the same cycle.
module mono_tx_hit_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 26,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         push_acc,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  occ
);
  localparam int OW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok;

  assign full     = (occ == OW'(DEPTH));
  assign empty    = (occ == '0);
  assign pop_ok   = pop && !empty;
  assign push_acc = push && (!full || pop_ok);
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)   rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + OW'(push_acc) - OW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mono_data_tx_emu.sv
// MONOPIX column readout transmitter emulator: hit buffer, freeze snapshot, READ-driven serialiser.
// Define MONO_TX_GRAY_EN to Gray-encode LE/TE at pop time; otherwise they are sent in binary.
module mono_data_tx_emu
  import mono_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int READ_DLY = 2
) (
  input  logic              CLK40,
  input  logic              nRST,
  mono_data_tx_emu_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int BW = $clog2(WB);

  tx_state_t     state;
  logic [WB-1:0] head, word_enc, shifter;
  logic [OW-1:0] occ, occ_next, frozen_cnt, frozen_next;
  logic [3:0]    dly_cnt;
  logic [BW-1:0] bit_cnt;
  logic          full, empty, push_acc;
  logic          read_q, freeze_q, read_rise, freeze_rise, readable, accept;
  logic          token, data, busy;
  logic [7:0]    lost_cnt, read_err;

  mono_tx_hit_fifo #(.DEPTH(DEPTH), .W(WB)) u_fifo (
    .clk(CLK40), .rst_n(nRST),
    .push(bus.HIT_WR), .din({bus.HIT_COL, bus.HIT_ROW, bus.HIT_LE, bus.HIT_TE}),
    .pop(accept), .dout(head), .push_acc(push_acc),
    .full(full), .empty(empty), .occ(occ)
  );

  assign read_rise   = bus.READ && !read_q;
  assign freeze_rise = bus.FREEZE && !freeze_q;
  assign readable    = bus.FREEZE ? (frozen_cnt != '0) : !empty;
  assign accept      = read_rise && (state == IDLE) && readable;
  assign occ_next    = occ + OW'(push_acc) - OW'(accept);

  // Hits pushed while frozen raise occupancy but never the frozen count.
  always_comb begin
    frozen_next = frozen_cnt;
    if (!bus.FREEZE)  frozen_next = '0;
    else if (freeze_rise) frozen_next = occ;
    else if (accept)  frozen_next = frozen_cnt - OW'(1);
  end

  always_comb begin
`ifdef MONO_TX_GRAY_EN
    word_enc = {head[WB-1 -: COL_BITS+ROW_BITS],
                bin2gray(head[2*TS_BITS-1 -: TS_BITS]), bin2gray(head[TS_BITS-1:0])};
`else
    word_enc = head;
`endif
  end

  always_ff @(posedge CLK40 or negedge nRST) begin
    if (!nRST) begin
      read_q     <= 1'b0;
      freeze_q   <= 1'b0;
      frozen_cnt <= '0;
      token      <= 1'b0;
      lost_cnt   <= '0;
      read_err   <= '0;
    end else begin
      read_q     <= bus.READ;
      freeze_q   <= bus.FREEZE;
      frozen_cnt <= frozen_next;
      token      <= bus.FREEZE ? (frozen_next != '0) : (occ_next != '0);
      if (bus.HIT_WR && !push_acc && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
      if (read_rise && !accept && read_err != 8'hFF)    read_err <= read_err + 8'd1;
    end
  end

  // DATA is registered from the shifter MSB, so the first bit lands READ_DLY+2 edges after acceptance.
  always_ff @(posedge CLK40 or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      shifter <= '0;
      dly_cnt <= '0;
      bit_cnt <= '0;
      data    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data <= 1'b0;
          if (accept) begin
            state   <= LOAD;
            shifter <= word_enc;
            dly_cnt <= 4'(READ_DLY);
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          data <= 1'b0;
          if (dly_cnt == 4'd0) state <= SHIFT;
          else dly_cnt <= dly_cnt - 4'd1;
        end
        SHIFT: begin
          data    <= shifter[WB-1];
          shifter <= shifter << 1;
          if (bit_cnt == BW'(WB-1)) begin
            state   <= IDLE;
            bit_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          data  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TOKEN    = token;
  assign bus.DATA     = data;
  assign bus.BUSY     = busy;
  assign bus.LOST_CNT = lost_cnt;
  assign bus.READ_ERR = read_err;
endmodule
